// File: rtl/dispatch_queue_if.sv
// Decoder-side and dispatch-side handshake bundle for dispatch_queue.
// The slave modport is the queue. The master modport is the decoder, the RS and the ROB side.
interface dispatch_queue_if #(
  parameter int NUM_FU   = 4,
  parameter int FU_IDX_W = 3,
  parameter int ENTRY_W  = 128
);
  logic                in_valid;
  logic                in_ready;
  logic [FU_IDX_W-1:0] in_fu;
  logic [ENTRY_W-1:0]  in_payload;
  logic [NUM_FU-1:0]   rs_full;
  logic                rob_full;
  logic                out_valid;
  logic [FU_IDX_W-1:0] out_fu;
  logic [ENTRY_W-1:0]  out_payload;
  logic [NUM_FU-1:0]   rs_load;
  logic                rob_alloc;

  modport slave (
    input  in_valid, in_fu, in_payload, rs_full, rob_full,
    output in_ready, out_valid, out_fu, out_payload, rs_load, rob_alloc
  );

  modport master (
    output in_valid, in_fu, in_payload, rs_full, rob_full,
    input  in_ready, out_valid, out_fu, out_payload, rs_load, rob_alloc
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order DEPTH-entry dispatch queue between the decoder and NUM_FU reservation stations.
// It dispatches at most one head entry per cycle and counts the cycles in which the head is blocked.
module dispatch_queue #(
  parameter int DEPTH    = 8,
  parameter int NUM_FU   = 4,
  parameter int FU_IDX_W = 3,
  parameter int ENTRY_W  = 128,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  dispatch_queue_if.slave        dq,
  input  logic                   flush,
  output logic                   stall,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       blocked_cycles
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0]  payload_mem [DEPTH];
  logic [FU_IDX_W-1:0] fu_mem      [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic                full;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                enq;
  logic                rs_ok;
  logic                fire;
  logic [NUM_FU-1:0]   rs_load_c;

  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign in_ready_c  = !full && !flush;
  assign out_valid_c = (count != '0);
  assign enq         = dq.in_valid && in_ready_c;

  // An FU index outside the RS range is a ROB-only entry, so no RS can hold it back.
  always_comb begin
    rs_ok     = 1'b1;
    rs_load_c = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_mem[head] == FU_IDX_W'(i)) rs_ok = !dq.rs_full[i];
    end
    fire = out_valid_c && !flush && !dq.rob_full && rs_ok;
    for (int i = 0; i < NUM_FU; i++) begin
      if (fire && fu_mem[head] == FU_IDX_W'(i)) rs_load_c[i] = 1'b1;
    end
  end

  assign dq.in_ready    = in_ready_c;
  assign dq.out_valid   = out_valid_c;
  assign dq.out_fu      = fu_mem[head];
  assign dq.out_payload = payload_mem[head];
  assign dq.rs_load     = rs_load_c;
  assign dq.rob_alloc   = fire;
  assign stall          = !in_ready_c;

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      payload_mem[tail] <= dq.in_payload;
      fu_mem[tail]      <= dq.in_fu;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      blocked_cycles <= '0;
    end else begin
      if (out_valid_c && !fire && !flush && blocked_cycles != '1)
        blocked_cycles <= blocked_cycles + 1'b1;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq)  tail <= tail + 1'b1;
        if (fire) head <= head + 1'b1;
        if (enq && !fire)      count <= count + 1'b1;
        else if (fire && !enq) count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue with DEPTH=8 and NUM_FU=4.
module tb_dispatch_queue;
  logic         clk;
  logic         reset;
  logic         flush;
  logic         stall;
  logic [3:0]   count;
  logic [15:0]  blocked_cycles;
  int           errors;
  int           checks;

  dispatch_queue_if #(.NUM_FU(4), .FU_IDX_W(3), .ENTRY_W(128)) dq_if ();

  dispatch_queue #(.DEPTH(8), .NUM_FU(4), .FU_IDX_W(3), .ENTRY_W(128), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dq(dq_if), .flush(flush),
    .stall(stall), .count(count), .blocked_cycles(blocked_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] fu, input logic [127:0] p);
    dq_if.in_valid   = v;
    dq_if.in_fu      = fu;
    dq_if.in_payload = p;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0;
    dq_if.rs_full = 4'b0000; dq_if.rob_full = 1'b0;
    drive(1'b0, 3'd0, 128'h0);
    tick(); tick();
    reset = 1'b1;
    tick(); #1;
    checks++; if (dq_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", dq_if.out_valid); end
    checks++; if (dq_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", dq_if.in_ready); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0h exp=0", stall); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (dq_if.rs_load !== 4'b0000) begin errors++; $display("FAIL reset_rs_load got=%b exp=0000", dq_if.rs_load); end
    checks++; if (dq_if.rob_alloc !== 1'b0) begin errors++; $display("FAIL reset_rob_alloc got=%0h exp=0", dq_if.rob_alloc); end
    checks++; if (blocked_cycles !== 16'd0) begin errors++; $display("FAIL reset_blocked got=%0d exp=0", blocked_cycles); end
  endtask

  task automatic test_basic();
    drive(1'b1, 3'd0, 128'hA); #1;
    checks++; if (dq_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass got=%0h exp=0", dq_if.out_valid); end
    tick();
    drive(1'b0, 3'd0, 128'h0); #1;
    checks++; if (dq_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%0h exp=1", dq_if.out_valid); end
    checks++; if (dq_if.rs_load !== 4'b0001) begin errors++; $display("FAIL basic_rs_load got=%b exp=0001", dq_if.rs_load); end
    checks++; if (dq_if.rob_alloc !== 1'b1) begin errors++; $display("FAIL basic_rob_alloc got=%0h exp=1", dq_if.rob_alloc); end
    checks++; if (dq_if.out_payload !== 128'hA) begin errors++; $display("FAIL basic_payload got=%0h exp=a", dq_if.out_payload); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count1 got=%0d exp=1", count); end
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL basic_count0 got=%0d exp=0", count); end
  endtask

  task automatic test_blocked();
    dq_if.rs_full = 4'b0010;
    drive(1'b1, 3'd1, 128'h11); tick();
    drive(1'b1, 3'd0, 128'h10); tick();
    drive(1'b0, 3'd0, 128'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (dq_if.rs_load !== 4'b0000 || dq_if.rob_alloc !== 1'b0) begin errors++; $display("FAIL blocked_hold%0d rs_load=%b rob_alloc=%0h exp=0000/0", i, dq_if.rs_load, dq_if.rob_alloc); end
      tick();
    end
    tick();
    checks++; if (blocked_cycles !== 16'd5) begin errors++; $display("FAIL blocked_count got=%0d exp=5", blocked_cycles); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL blocked_occupancy got=%0d exp=2", count); end
    dq_if.rs_full = 4'b0000; #1;
    checks++; if (dq_if.rs_load !== 4'b0010 || dq_if.out_payload !== 128'h11) begin errors++; $display("FAIL blocked_release1 rs_load=%b payload=%0h exp=0010/11", dq_if.rs_load, dq_if.out_payload); end
    tick();
    checks++; if (dq_if.rs_load !== 4'b0001 || dq_if.out_payload !== 128'h10) begin errors++; $display("FAIL blocked_release2 rs_load=%b payload=%0h exp=0001/10", dq_if.rs_load, dq_if.out_payload); end
    tick();
    checks++; if (count !== 4'd0 || blocked_cycles !== 16'd5) begin errors++; $display("FAIL blocked_drain count=%0d blocked=%0d exp=0/5", count, blocked_cycles); end
  endtask

  task automatic test_rob_full();
    dq_if.rob_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd0, 128'(i)); #1;
      checks++; if (dq_if.in_ready !== (i < 8)) begin errors++; $display("FAIL robfull_in_ready%0d got=%0h exp=%0h", i, dq_if.in_ready, (i < 8)); end
      tick();
    end
    drive(1'b0, 3'd0, 128'h0);
    checks++; if (count !== 4'd8 || stall !== 1'b1) begin errors++; $display("FAIL robfull_full count=%0d stall=%0h exp=8/1", count, stall); end
    checks++; if (blocked_cycles !== 16'd14) begin errors++; $display("FAIL robfull_blocked got=%0d exp=14", blocked_cycles); end
    dq_if.rob_full = 1'b0; #1;
    checks++; if (dq_if.rob_alloc !== 1'b1 || dq_if.in_ready !== 1'b0) begin errors++; $display("FAIL robfull_fire_full rob_alloc=%0h in_ready=%0h exp=1/0", dq_if.rob_alloc, dq_if.in_ready); end
    checks++; if (dq_if.out_payload !== 128'd0) begin errors++; $display("FAIL robfull_payload0 got=%0h exp=0", dq_if.out_payload); end
    tick();
    checks++; if (count !== 4'd7 || dq_if.in_ready !== 1'b1) begin errors++; $display("FAIL robfull_ready_back count=%0d in_ready=%0h exp=7/1", count, dq_if.in_ready); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (dq_if.out_payload !== 128'(i) || dq_if.rob_alloc !== 1'b1) begin errors++; $display("FAIL robfull_order%0d got=%0h exp=%0h", i, dq_if.out_payload, i); end
      tick();
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL robfull_empty got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 3'(k % 4), 128'(100 + k)); #1;
      if (k > 0) begin
        checks++; if (dq_if.out_payload !== 128'(99 + k) || dq_if.rob_alloc !== 1'b1) begin errors++; $display("FAIL b2b_payload%0d got=%0h exp=%0h", k, dq_if.out_payload, 99 + k); end
      end
      tick();
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL b2b_count%0d got=%0d exp=1", k, count); end
    end
    drive(1'b0, 3'd0, 128'h0); #1;
    checks++; if (dq_if.out_payload !== 128'd119 || dq_if.rs_load !== 4'b1000) begin errors++; $display("FAIL b2b_last payload=%0h rs_load=%b exp=77/1000", dq_if.out_payload, dq_if.rs_load); end
    tick();
  endtask

  task automatic test_flush();
    dq_if.rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'd2, 128'(200 + i)); tick();
    end
    dq_if.rob_full = 1'b0; flush = 1'b1;
    drive(1'b1, 3'd2, 128'hEE); #1;
    checks++; if (dq_if.rob_alloc !== 1'b0 || dq_if.rs_load !== 4'b0000) begin errors++; $display("FAIL flush_no_fire rob_alloc=%0h rs_load=%b exp=0/0000", dq_if.rob_alloc, dq_if.rs_load); end
    checks++; if (dq_if.in_ready !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL flush_in_ready in_ready=%0h stall=%0h exp=0/1", dq_if.in_ready, stall); end
    tick();
    flush = 1'b0;
    drive(1'b0, 3'd0, 128'h0);
    checks++; if (count !== 4'd0 || dq_if.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty count=%0d out_valid=%0h exp=0/0", count, dq_if.out_valid); end
    checks++; if (blocked_cycles !== 16'd18) begin errors++; $display("FAIL flush_blocked got=%0d exp=18", blocked_cycles); end
    drive(1'b1, 3'd2, 128'hF1); tick();
    drive(1'b0, 3'd0, 128'h0); #1;
    checks++; if (dut.head !== 3'd0 || dq_if.out_payload !== 128'hF1 || dq_if.rs_load !== 4'b0100) begin errors++; $display("FAIL flush_slot0 head=%0d payload=%0h rs_load=%b exp=0/f1/0100", dut.head, dq_if.out_payload, dq_if.rs_load); end
    tick();
  endtask

  task automatic test_nop_and_reset();
    drive(1'b1, 3'd5, 128'h55); tick();
    drive(1'b0, 3'd0, 128'h0); #1;
    checks++; if (dq_if.rob_alloc !== 1'b1 || dq_if.rs_load !== 4'b0000) begin errors++; $display("FAIL nop_dispatch rob_alloc=%0h rs_load=%b exp=1/0000", dq_if.rob_alloc, dq_if.rs_load); end
    tick();
    dq_if.rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd1, 128'(300 + i)); tick();
    end
    #2;
    reset = 1'b0; #1;
    checks++; if (dq_if.out_valid !== 1'b0 || count !== 4'd0 || dq_if.in_ready !== 1'b1) begin errors++; $display("FAIL async_reset out_valid=%0h count=%0d in_ready=%0h exp=0/0/1", dq_if.out_valid, count, dq_if.in_ready); end
    checks++; if (blocked_cycles !== 16'd0 || stall !== 1'b0) begin errors++; $display("FAIL async_reset_blocked blocked=%0d stall=%0h exp=0/0", blocked_cycles, stall); end
    drive(1'b0, 3'd0, 128'h0);
    dq_if.rob_full = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_count got=%0d exp=0", count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_blocked();
    test_rob_full();
    test_back_to_back();
    test_flush();
    test_nop_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
